game_physics: RTL

GAME_PHYSICS -- requirements
Module: game_physics

---
 rtl/game_physics.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_physics.sv
// Pong game physics: pads, ball, scores and IDLE/SERVE/PLAY/POINT/OVER sequencing.
// Latency: all outputs registered, updated on the clock edge that samples frame_tick.
// Backpressure: none; frame_tick and start are single-cycle pulses, buttons are levels.
module game_physics #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PAD_DISTANCE  = 20,
  parameter int PAD_WIDTH     = 8,
  parameter int PAD_HEIGHT    = 64,
  parameter int BALL_R        = 3,
  parameter int BALL_SPEED    = 2,
  parameter int PAD_SPEED     = 4
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       start,
  output logic [8:0] pad_left,
  output logic [8:0] pad_right,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);
  localparam int PAD_MIN = PAD_HEIGHT / 2 + 1;
  localparam int PAD_MAX = SCREEN_HEIGHT - 2 - PAD_HEIGHT / 2;
  localparam int HIT_Y   = PAD_HEIGHT / 2 + BALL_R;
  localparam logic [9:0] CENTRE_X   = 10'(SCREEN_WIDTH / 2);
  localparam logic [8:0] CENTRE_Y   = 9'(SCREEN_HEIGHT / 2);
  localparam logic [5:0] SERVE_LAST = 6'd59;
  localparam logic [5:0] POINT_LAST = 6'd29;

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  state_t     state, state_nxt;
  logic [8:0] pad_left_nxt, pad_right_nxt, ball_y_nxt;
  logic [9:0] ball_x_nxt;
  logic [3:0] score_left_nxt, score_right_nxt;
  logic [5:0] frame_cnt, frame_cnt_nxt;
  logic       dx, dx_nxt;  // 1 = moving right
  logic       dy, dy_nxt;  // 1 = moving down
  int         bx, by, dist_l, dist_r;
  logic       wall_hit, left_hit, right_hit, miss_left, miss_right;

  // Signed arithmetic keeps the lower clamp free of unsigned underflow.
  function automatic logic [8:0] pad_step(input logic [8:0] pad, input logic up, input logic down);
    int p;
    p = int'(pad);
    if (up && !down)
      p = (p - PAD_SPEED < PAD_MIN) ? PAD_MIN : p - PAD_SPEED;
    else if (down && !up)
      p = (p + PAD_SPEED > PAD_MAX) ? PAD_MAX : p + PAD_SPEED;
    return p[8:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  // Collision and miss predicates, all from pre-update register values.
  assign bx         = int'(ball_x);
  assign by         = int'(ball_y);
  assign dist_l     = (by >= int'(pad_left))  ? by - int'(pad_left)  : int'(pad_left) - by;
  assign dist_r     = (by >= int'(pad_right)) ? by - int'(pad_right) : int'(pad_right) - by;
  assign wall_hit   = dy ? (by + BALL_R >= SCREEN_HEIGHT - 2) : (by - BALL_R <= 1);
  assign left_hit   = !dx && (bx - BALL_R >= PAD_DISTANCE) &&
                      (bx - BALL_R <= PAD_DISTANCE + PAD_WIDTH) && (dist_l <= HIT_Y);
  assign right_hit  = dx && (bx + BALL_R >= SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH) &&
                      (bx + BALL_R <= SCREEN_WIDTH - PAD_DISTANCE) && (dist_r <= HIT_Y);
  assign miss_left  = !dx && (bx <= BALL_R);
  assign miss_right = dx && (bx >= SCREEN_WIDTH - 1 - BALL_R);
  assign game_over  = (state == OVER);

  // Next-state and datapath: pads per frame, start restarts from IDLE/OVER, ball per state.
  always_comb begin
    state_nxt       = state;
    pad_left_nxt    = pad_left;
    pad_right_nxt   = pad_right;
    ball_x_nxt      = ball_x;
    ball_y_nxt      = ball_y;
    dx_nxt          = dx;
    dy_nxt          = dy;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    frame_cnt_nxt   = frame_cnt;

    if (frame_tick && state != OVER) begin
      pad_left_nxt  = pad_step(pad_left, left_up, left_down);
      pad_right_nxt = pad_step(pad_right, right_up, right_down);
    end

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt       = SERVE;
          score_left_nxt  = 4'd0;
          score_right_nxt = 4'd0;
          frame_cnt_nxt   = 6'd0;
          ball_x_nxt      = CENTRE_X;
          ball_y_nxt      = CENTRE_Y;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == SERVE_LAST) begin
            state_nxt     = PLAY;
            frame_cnt_nxt = 6'd0;
          end else begin
            frame_cnt_nxt = frame_cnt + 6'd1;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (miss_left) begin
            score_right_nxt = sat_inc(score_right);
            dx_nxt          = 1'b0;
            state_nxt       = POINT;
            frame_cnt_nxt   = 6'd0;
          end else if (miss_right) begin
            score_left_nxt = sat_inc(score_left);
            dx_nxt         = 1'b1;
            state_nxt      = POINT;
            frame_cnt_nxt  = 6'd0;
          end else begin
            // A bounce flips the axis and skips that axis' step for the frame.
            if (left_hit || right_hit) dx_nxt = ~dx;
            else ball_x_nxt = dx ? ball_x + 10'(BALL_SPEED) : ball_x - 10'(BALL_SPEED);
            if (wall_hit) dy_nxt = ~dy;
            else ball_y_nxt = dy ? ball_y + 9'(BALL_SPEED) : ball_y - 9'(BALL_SPEED);
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (frame_cnt == POINT_LAST) begin
            frame_cnt_nxt = 6'd0;
            if (score_left == 4'd9 || score_right == 4'd9) begin
              state_nxt = OVER;
            end else begin
              state_nxt  = SERVE;
              ball_x_nxt = CENTRE_X;
              ball_y_nxt = CENTRE_Y;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset overriding every other input.
  always_ff @(posedge clk_vga) begin
    if (!rst) begin
      state       <= IDLE;
      pad_left    <= CENTRE_Y;
      pad_right   <= CENTRE_Y;
      ball_x      <= CENTRE_X;
      ball_y      <= CENTRE_Y;
      dx          <= 1'b1;
      dy          <= 1'b1;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      frame_cnt   <= 6'd0;
    end else begin
      state       <= state_nxt;
      pad_left    <= pad_left_nxt;
      pad_right   <= pad_right_nxt;
      ball_x      <= ball_x_nxt;
      ball_y      <= ball_y_nxt;
      dx          <= dx_nxt;
      dy          <= dy_nxt;
      score_left  <= score_left_nxt;
      score_right <= score_right_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end
endmodule
